// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame geometry and the serializer state encoding.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_DATA_W     = 8;
    // Start bit + data bits + stop bit.
    localparam int unsigned UART_FRAME_BITS = UART_DATA_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request at or above ptr, with wrap.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    int unsigned k;

    // Walk offsets from farthest to nearest so the nearest active request is written last.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        k           = 0;
        for (int unsigned off = NUM_REQ; off > 0; off--) begin
            k = (32'(ptr) + off - 1) % NUM_REQ;
            if (req[k]) begin
                grant       = '0;
                grant[k]    = 1'b1;
                grant_idx   = IDX_W'(k);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 UART transmit line between NUM_REQ byte producers using round-robin arbitration.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned DATA_W     = UART_DATA_W,
    parameter  int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    localparam int unsigned ID_W       = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      baud_tick,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end
    if (OVERSAMPLE < 2) begin : g_bad_oversample
        $error("uart_tx_arbiter: OVERSAMPLE must be at least 2");
    end

    uart_state_e         state_q, state_d;
    logic [CNT_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [ID_W-1:0]     arb_idx;
    logic                arb_valid;
    logic                bit_end;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req         (req_valid),
        .ptr         (ptr_q),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    assign req_ready = (state_q == IDLE) ? arb_grant : '0;
    assign bit_end   = baud_tick && (tick_q == CNT_W'(OVERSAMPLE - 1));

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;

        if (state_q != IDLE && baud_tick) begin
            tick_d = bit_end ? '0 : tick_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    shift_d    = req_data[32'(arb_idx)*DATA_W +: DATA_W];
                    grant_id_d = arb_idx;
                    busy_d     = 1'b1;
                    tick_d     = '0;
                    bit_d      = '0;
                    tx_d       = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        bit_d   = '0;
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = shift_d[0];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    ptr_d   = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            grant_id_q <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: decodes each frame off tx and compares against hand-computed bytes.
module tb_uart_tx_arbiter;

    localparam int unsigned TD = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        baud_tick = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        tx;
    logic        busy;
    logic [1:0]  grant_id;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned tick_ph = 0;

    uart_tx_arbiter #(
        .NUM_REQ    (4),
        .DATA_W     (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .baud_tick (baud_tick),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        tick_ph   = (tick_ph + 1) % TD;
        baud_tick = (tick_ph == 0);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        else n_pass++;
    endtask

    // Entered at the first negedge after the accept edge; returns at the negedge where busy is low.
    task automatic capture(output logic [7:0] d, output int unsigned ticks,
                           output bit ready_seen, output bit framing_ok, output bit timeout);
        int unsigned cyc = 0;
        d = '0; ticks = 0; ready_seen = 0; framing_ok = 1; timeout = 0;
        while (busy) begin
            if (req_ready != 4'b0) ready_seen = 1;
            if (baud_tick) begin
                ticks++;
                if (ticks == 8) framing_ok &= (tx == 1'b0);
                else if (ticks >= 24 && ticks <= 136 && (ticks - 8) % 16 == 0) d[(ticks - 24) / 16] = tx;
                else if (ticks == 152) framing_ok &= (tx == 1'b1);
            end
            cyc++;
            if (cyc > 2000) begin
                timeout = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Must be entered at a negedge.
    task automatic do_frame(input string tag, input logic [3:0] mask, input int unsigned exp_idx,
                            input logic [7:0] exp_data, input bit drop, input bit scribble);
        int unsigned w = 0;
        logic [7:0] d;
        int unsigned ticks;
        bit rs, fok, to;
        req_valid = mask;
        #1;
        while (req_ready == 4'b0 && w < 50) begin
            @(negedge clk); #1; w++;
        end
        check({tag, ".ready"}, 32'(req_ready), 32'(1) << exp_idx);
        if (req_ready == 4'b0) return;
        @(posedge clk); #1;
        if (drop) req_valid = '0;
        if (scribble) req_data[exp_idx*8 +: 8] = 8'hFF;
        @(negedge clk);
        check({tag, ".ready_pulse"}, 32'(req_ready), 32'h0);
        check({tag, ".busy"}, 32'(busy), 32'h1);
        check({tag, ".start"}, 32'(tx), 32'h0);
        check({tag, ".grant_id"}, 32'(grant_id), 32'(exp_idx));
        capture(d, ticks, rs, fok, to);
        check({tag, ".timeout"}, 32'(to), 32'h0);
        check({tag, ".data"}, 32'(d), 32'(exp_data));
        check({tag, ".framing"}, 32'(fok), 32'h1);
        check({tag, ".ready_during_frame"}, 32'(rs), 32'h0);
        check({tag, ".latency_ticks"}, 32'(ticks >= 159 && ticks <= 160), 32'h1);
        check({tag, ".tx_idle"}, 32'(tx), 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] fair_data [4];
        int unsigned ticks, cyc;
        bit bad_tx, bad_busy;

        fair_data[0] = 8'h10; fair_data[1] = 8'h21; fair_data[2] = 8'h32; fair_data[3] = 8'h43;

        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset.tx", 32'(tx), 32'h1);
        check("reset.busy", 32'(busy), 32'h0);
        check("reset.ready", 32'(req_ready), 32'h0);
        check("reset.grant_id", 32'(grant_id), 32'h0);

        req_data[2*8 +: 8] = 8'hA5;
        do_frame("single", 4'b0100, 2, 8'hA5, 1, 0);

        ticks = 0; cyc = 0; bad_tx = 0; bad_busy = 0;
        while (ticks < 100 && cyc < 1000) begin
            @(negedge clk);
            if (baud_tick) ticks++;
            if (tx !== 1'b1) bad_tx = 1;
            if (busy !== 1'b0) bad_busy = 1;
            cyc++;
        end
        check("idle.tick_count", 32'(ticks), 32'd100);
        check("idle.tx", 32'(bad_tx), 32'h0);
        check("idle.busy", 32'(bad_busy), 32'h0);
        check("idle.grant_id_held", 32'(grant_id), 32'h2);

        req_data[0 +: 8] = 8'h3C;
        do_frame("stable", 4'b0001, 0, 8'h3C, 1, 1);

        req_data[1*8 +: 8] = 8'h5A;
        req_valid = 4'b0010;
        @(posedge clk); #1;
        req_valid = '0;
        ticks = 0; cyc = 0;
        while (ticks < 72 && cyc < 1000) begin
            @(negedge clk);
            if (baud_tick) ticks++;
            cyc++;
        end
        check("midreset.reached_bit3", 32'(ticks), 32'd72);
        check("midreset.busy_before", 32'(busy), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check("midreset.tx", 32'(tx), 32'h1);
        check("midreset.busy", 32'(busy), 32'h0);
        check("midreset.ready", 32'(req_ready), 32'h0);
        check("midreset.grant_id", 32'(grant_id), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        req_data = {fair_data[3], fair_data[2], fair_data[1], fair_data[0]};
        for (int unsigned i = 0; i < 8; i++) begin
            do_frame($sformatf("fair%0d", i), 4'b1111, i % 4, fair_data[i % 4], 0, 0);
        end

        do_frame("wrap_a", 4'b1010, 1, 8'h21, 0, 0);
        do_frame("wrap_b", 4'b1010, 3, 8'h43, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit line between NUM_REQ independent byte producers.
- Round-robin arbitration over the requesters; serializes the winner's byte as 8N1 framing.
- Bit timing comes from the existing 16x-oversample baud tick generator (one tick = 1/16 bit period).
- Sits between the producer blocks and the board TX pin; the baud generator feeds its baud_tick input.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- DATA_W, 8, data bits per frame; LSB first.
- OVERSAMPLE, 16, baud_tick pulses per bit period; must match the baud generator's divider.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- baud_tick  input  1  single-cycle pulse at 16x the baud rate.
- req_valid  input  NUM_REQ  per-requester "byte available"; held until accepted.
- req_data  input  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot accept; transfer occurs when req_valid[i] && req_ready[i] at a rising clk edge.
- tx  output  1  serial line; idle high.
- busy  output  1  high from the accept edge until the stop bit completes.
- grant_id  output  clog2(NUM_REQ)  index of the requester currently being transmitted; holds the last value when idle.

Behaviour:
- Reset is synchronous, active-high. Reset values: tx=1, busy=0, req_ready=0, grant_id=0, round-robin pointer=0, state=IDLE, counters=0.
- Reset mid-frame aborts the frame; tx returns high on the next edge.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE:
  - req_ready is combinational. It is one-hot on the first i with req_valid[i]=1, searching from the pointer upward with wrap-around.
  - req_ready is zero in every other state and whenever no valid is asserted.
  - On the accept edge: the byte is latched into the shift register, grant_id is set to the winner, busy=1, state goes to START, tick counter is cleared.
- Bit timing:
  - The tick counter increments on baud_tick only.
  - A bit ends on the baud_tick where the counter equals OVERSAMPLE-1; the counter then wraps to 0.
  - baud_tick pulses in IDLE are ignored.
  - The first (start) bit may be up to one tick short because of tick phase; this tolerance is accepted.
- START: tx=0 (registered, effective from the cycle after the accept edge).
- DATA:
  - tx = shift_reg[0].
  - Each bit end shifts right and increments the bit counter.
  - After DATA_W bits, go to STOP.
- STOP:
  - tx=1 for OVERSAMPLE ticks.
  - At the end: state=IDLE, busy=0, pointer = grant_id+1 (mod NUM_REQ).
- Back-to-back: the earliest re-accept is the first IDLE cycle after STOP. The same requester can win again only if no other requester is valid.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,...
- Frame latency: accept edge to stop-bit end = (DATA_W+2)*OVERSAMPLE ticks, minus at most one tick.
- req_valid dropping without an accept is legal; there is no state effect.
- req_data changes after the accept edge have no effect on the frame in flight.
- tx is driven from a register (no combinational glitches on the pin).

Decomposition:
- Shared package uart_pkg holds:
  - UART_OVERSAMPLE=16, UART_DATA_W=8;
  - the state enum (IDLE, START, DATA, STOP);
  - the frame length constant (DATA_W+2).
- One natural sub-module: rr_arbiter (NUM_REQ). Inputs: req vector, pointer. Output: one-hot grant plus encoded index. Purely combinational and reusable by the future RX and command-bus blocks.
- The serializer FSM stays in uart_tx_arbiter.

Test Plan:
- Reset mid-frame, in the DATA state on bit 3 -> next edge: tx=1, busy=0, req_ready=0. After release, a new request sends a full frame normally.
- Single request: req_valid[2]=1, data 0xA5 -> req_ready[2] pulses for one cycle; grant_id=2. tx shows start 0, then bits 1,0,1,0,0,1,0,1, then stop 1, each bit 16 ticks long. busy drops after 160 ticks (±1).
- All four valid continuously with data 0x10,0x21,0x32,0x43 -> frames emitted in order 0,1,2,3,0. Each req_ready is a one-cycle pulse and never overlaps another.
- Pointer wrap: after grant 3, requesters 1 and 3 are valid -> 1 is granted next, then 3.
- Ticks while idle: 100 baud_ticks with no requests -> tx stays 1, busy stays 0, counters stay 0.
- Data stability: after the accept of 0x3C, req_data[0] is changed to 0xFF mid-frame -> the serialized bits still decode to 0x3C.
